// File: rtl/bin_to_bcd.sv
// bin_to_bcd: iterative double-dabble binary-to-BCD converter.
// Produces eight nibble-per-digit BCD digits for the seven-segment path.
// Conversions above 99_999_999 saturate to all nines and raise ovf.
// With BLANK=1, leading zero digits (except digit 0) read as 4'hF.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold the last result
// S_SHIFT | one add-3/shift iteration per cycle, W iterations total
// S_FIX   | saturate or blank the accumulator, publish result, pulse done
module bin_to_bcd #(
    parameter int W     = 27,
    parameter bit BLANK = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [31:0]  bcd,
    output logic         ovf
);

    localparam int          CW      = $clog2(W + 1);
    localparam logic [31:0] RST_BCD = BLANK ? 32'hFFFF_FFF0 : 32'h0000_0000;
    localparam logic [31:0] MAX_DEC = 32'd99_999_999;
    localparam logic [31:0] SAT_BCD = 32'h9999_9999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_FIX   = 2'd2
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_shreg;
    logic [31:0]     r_acc;
    logic [CW-1:0]   r_cnt;
    logic            r_sat;

    logic [31:0]     w_adj;
    logic [31:0]     w_blank;
    logic            w_sat_in;

    // Saturation is decided from the captured value, so iteration timing never changes.
    assign w_sat_in = ({{(32-W){1'b0}}, bin} > MAX_DEC);

    // Add 3 to every digit that would reach 10 or more after the next doubling.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < 8; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Replace leading zero digits 7..1 with 4'hF; digit 0 always stays visible.
    always_comb begin
        logic lead;
        w_blank = r_acc;
        lead    = 1'b1;
        if (BLANK) begin
            for (int i = 7; i >= 1; i--) begin
                if (lead && (r_acc[4*i +: 4] == 4'd0)) begin
                    w_blank[4*i +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    // Controller and datapath: capture, iterate W times, then publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd     <= RST_BCD;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shreg <= bin;
                        r_acc   <= '0;
                        r_cnt   <= CW'(W);
                        r_sat   <= w_sat_in;
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_acc   <= (w_adj << 1) | {31'd0, r_shreg[W-1]};
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    bcd     <= r_sat ? SAT_BCD : w_blank;
                    ovf     <= r_sat;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Self-checking bench for bin_to_bcd: directed and random conversions compared
// against a decimal-arithmetic reference, plus handshake and reset-abort cases.
module tb_bin_to_bcd;

    localparam int W = 27;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  bin;
    logic          busy1, done1, ovf1;
    logic [31:0]   bcd1;
    logic          busy0, done0, ovf0;
    logic [31:0]   bcd0;

    int            total;
    int            bad;
    int            done_cnt;
    logic [31:0]   prev1;

    bin_to_bcd #(.W(W), .BLANK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy1), .done(done1), .bcd(bcd1), .ovf(ovf1)
    );

    bin_to_bcd #(.W(W), .BLANK(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
        .busy(busy0), .done(done0), .bcd(bcd0), .ovf(ovf0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done1 === 1'b1) done_cnt++;
    end

    // Reference: decimal digits by division, saturation above 99_999_999,
    // then blank every digit above the most significant nonzero one.
    function automatic logic [31:0] model(input int v, input bit blank, output bit ov);
        logic [31:0] r;
        int t, top, d;
        if (v > 99_999_999) begin
            ov = 1'b1;
            return 32'h9999_9999;
        end
        ov  = 1'b0;
        r   = '0;
        t   = v;
        top = 0;
        for (int i = 0; i < 8; i++) begin
            d = t % 10;
            t = t / 10;
            r[4*i +: 4] = 4'(d);
            if (d != 0) top = i;
        end
        if (blank) begin
            for (int i = 1; i < 8; i++) begin
                if (i > top) r[4*i +: 4] = 4'hF;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_conv(input int v);
        logic [31:0] e1, e0;
        bit ov, ov0;
        int n;
        e1 = model(v, 1'b1, ov);
        e0 = model(v, 1'b0, ov0);
        @(negedge clk);
        start = 1'b1;
        bin   = W'(v);
        @(posedge clk); #1;
        start = 1'b0;
        bin   = W'($urandom);
        chk("busy_after_accept", {31'd0, busy1}, 32'd1);
        chk("bcd_hold_while_busy", bcd1, prev1);
        n = 0;
        while (done1 !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, W + 1);
        chk("bcd_blank", bcd1, e1);
        chk("bcd_plain", bcd0, e0);
        chk("ovf_blank", {31'd0, ovf1}, {31'd0, ov});
        chk("ovf_plain", {31'd0, ovf0}, {31'd0, ov0});
        chk("busy_at_done", {31'd0, busy1}, 32'd0);
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done1}, 32'd0);
        prev1 = e1;
    endtask

    initial begin
        int vals[3];
        int n, d0;
        logic [31:0] e;
        bit ov;

        total    = 0;
        bad      = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        bin      = '0;
        prev1    = 32'hFFFF_FFF0;

        #12;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_ovf", {31'd0, ovf1}, 32'd0);
        chk("rst_bcd_blank", bcd1, 32'hFFFF_FFF0);
        chk("rst_bcd_plain", bcd0, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        do_conv(0);
        do_conv(12_345_678);
        do_conv(99_999_999);
        do_conv(405);
        do_conv(1_000_000);
        do_conv(100_000_000);
        do_conv(7);
        do_conv(134_217_727);

        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) do_conv(int'($urandom_range(0, 134_217_727)));
            else            do_conv(int'($urandom_range(0, 99_999)));
        end

        // start pulsed every cycle while busy: only the first value converts
        vals[0] = 31_415;
        e  = model(vals[0], 1'b1, ov);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        bin   = W'(vals[0]);
        n = 0;
        while (n < 60) begin
            @(posedge clk); #1;
            n++;
            if (done1 === 1'b1) break;
            @(negedge clk);
            start = busy1;
            bin   = W'($urandom);
        end
        start = 1'b0;
        chk("hs_latency", n, W + 2);
        chk("hs_bcd", bcd1, e);
        repeat (3) @(negedge clk);
        chk("hs_single_done", done_cnt - d0, 32'd1);
        chk("hs_no_restart", {31'd0, busy1}, 32'd0);
        prev1 = e;

        // start held high: back-to-back conversions, one per W+2 cycles
        vals[0] = 8_675_309;
        vals[1] = 42;
        vals[2] = 90_000_001;
        @(negedge clk);
        start = 1'b1;
        bin   = W'(vals[0]);
        @(posedge clk); #1;
        n = 1;
        for (int j = 0; j < 3; j++) begin
            while (done1 !== 1'b1 && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b2b_interval", n, W + 2);
            e = model(vals[j], 1'b1, ov);
            chk("b2b_bcd", bcd1, e);
            if (j < 2) begin
                bin = W'(vals[j + 1]);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            chk("b2b_busy_gap", {31'd0, busy1}, (j < 2) ? 32'd1 : 32'd0);
            n = 1;
        end
        prev1 = e;

        // reset mid-conversion after a saturated result
        do_conv(100_000_000);
        @(negedge clk);
        start = 1'b1;
        bin   = W'(4321);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_ovf", {31'd0, ovf1}, 32'd0);
        chk("abort_bcd_blank", bcd1, 32'hFFFF_FFF0);
        chk("abort_bcd_plain", bcd0, 32'h0000_0000);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 32'd0);
        chk("abort_bcd_idle", bcd1, 32'hFFFF_FFF0);
        prev1 = 32'hFFFF_FFF0;
        do_conv(55);
        chk("after_abort_55", bcd1, 32'hFFFF_FF55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
